// File: rtl/sprite_pos_stream.sv
// Multi-sprite position controller: moves the selected sprite from buttons and streams one
// sprite word per sprite round-robin over valid/ready. Define SPRITE_POS_WRAP_EN to wrap.
module sprite_pos_stream #(
    parameter int unsigned NUM_SPRITES   = 4,
    parameter int unsigned X_MIN         = 0,
    parameter int unsigned X_MAX         = 620,
    parameter int unsigned Y_MIN         = 0,
    parameter int unsigned Y_MAX         = 460,
    parameter int unsigned STEP          = 1,
    parameter int unsigned HOLD_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter int unsigned OFFSET_BASE   = 0,
    parameter int unsigned OFFSET_STEP   = 1,
    parameter logic [2:0]  ACTIVE_CODE   = 3'b001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_select,
    output logic [2:0]  sel_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    localparam int unsigned IDX_W   = $clog2(NUM_SPRITES);
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_V   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REP_V    = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [10:0]      STEP_V   = 11'(STEP);
    localparam logic [10:0]      X_LO     = 11'(X_MIN);
    localparam logic [10:0]      X_HI     = 11'(X_MAX);
    localparam logic [10:0]      Y_LO     = 11'(Y_MIN);
    localparam logic [10:0]      Y_HI     = 11'(Y_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    // One step in either direction, bounded to [lo, hi].
    function automatic logic [9:0] move(input logic [9:0] pos, input logic up,
                                        input logic [10:0] lo, input logic [10:0] hi);
        logic [10:0] p;
        logic [10:0] r;
        p = {1'b0, pos};
        if (up) begin
            if (p + STEP_V > hi) begin
`ifdef SPRITE_POS_WRAP_EN
                r = lo + (p + STEP_V - hi - 11'd1);
`else
                r = hi;
`endif
            end else begin
                r = p + STEP_V;
            end
        end else begin
            if (p < lo + STEP_V) begin
`ifdef SPRITE_POS_WRAP_EN
                r = hi - (lo + STEP_V - p - 11'd1);
`else
                r = lo;
`endif
            end else begin
                r = p - STEP_V;
            end
        end
        return 10'(r);
    endfunction

    // Bit order: left, right, up, down, select; axis a uses bits 2a (neg) and 2a+1 (pos).
    logic [4:0]       btn;
    logic [4:0]       btn_q;
    logic             sel_press;
    logic [IDX_W-1:0] sel_q;
    logic [IDX_W-1:0] k_q;
    logic [IDX_W-1:0] k_next;
    logic [IDX_W-1:0] ld_idx;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    logic [1:0]       rep_q;
    logic [1:0]       rep_d;
    logic [1:0]       do_step;
    logic [1:0]       step_up;
    logic [9:0]       x_q [NUM_SPRITES];
    logic [9:0]       y_q [NUM_SPRITES];
    logic [9:0]       x_new;
    logic [9:0]       y_new;
    logic [31:0]      word;

    assign btn       = {btn_select, btn_down, btn_up, btn_right, btn_left};
    assign sel_press = btn[4] & ~btn_q[4];
    assign sel_idx   = 3'(sel_q);

    always_comb begin
        for (int a = 0; a < 2; a++) begin
            cnt_d[a]   = cnt_q[a];
            rep_d[a]   = rep_q[a];
            do_step[a] = 1'b0;
            step_up[a] = btn[2*a+1];
            // Idle or opposing buttons, or a select edge: no motion, restart the hold timer.
            if (sel_press || (btn[2*a] == btn[2*a+1])) begin
                cnt_d[a] = '0;
                rep_d[a] = 1'b0;
            end else if (btn[2*a+1] ? !btn_q[2*a+1] : !btn_q[2*a]) begin
                do_step[a] = 1'b1;
                cnt_d[a]   = CNT_ONE;
                rep_d[a]   = 1'b0;
            end else if (cnt_q[a] != '0) begin
                if (!rep_q[a] && cnt_q[a] == HOLD_V) begin
                    do_step[a] = 1'b1;
                    cnt_d[a]   = CNT_ONE;
                    rep_d[a]   = 1'b1;
                end else if (rep_q[a] && cnt_q[a] == REP_V) begin
                    do_step[a] = 1'b1;
                    cnt_d[a]   = CNT_ONE;
                end else begin
                    cnt_d[a] = cnt_q[a] + CNT_ONE;
                end
            end
        end
    end

    assign x_new = move(x_q[sel_q], step_up[0], X_LO, X_HI);
    assign y_new = move(y_q[sel_q], step_up[1], Y_LO, Y_HI);

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= '0;
            sel_q <= '0;
            rep_q <= '0;
            for (int a = 0; a < 2; a++) cnt_q[a] <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i] <= 10'(X_MIN);
                y_q[i] <= 10'(Y_MIN);
            end
        end else begin
            btn_q <= btn;
            rep_q <= rep_d;
            for (int a = 0; a < 2; a++) cnt_q[a] <= cnt_d[a];
            if (sel_press) sel_q <= (sel_q == LAST_IDX) ? '0 : sel_q + IDX_ONE;
            if (do_step[0]) x_q[sel_q] <= x_new;
            if (do_step[1]) y_q[sel_q] <= y_new;
        end
    end

    // Words sample position registers before this edge's commit.
    assign k_next = (k_q == LAST_IDX) ? '0 : k_q + IDX_ONE;
    assign ld_idx = out_valid ? k_next : k_q;
    assign word   = {ACTIVE_CODE, x_q[ld_idx], y_q[ld_idx],
                     9'(OFFSET_BASE + 32'(ld_idx) * OFFSET_STEP)};

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            k_q       <= '0;
        end else if (!out_valid) begin
            out_valid <= 1'b1;
            out       <= word;
        end else if (out_ready) begin
            out <= word;
            k_q <= k_next;
        end
    end

endmodule

// File: tb/tb_sprite_pos_stream.sv
// Directed self-checking bench for sprite_pos_stream (default and STEP=2 instances).
module tb_sprite_pos_stream;

    localparam logic [4:0] LEFT  = 5'b00001;
    localparam logic [4:0] RIGHT = 5'b00010;
    localparam logic [4:0] UP    = 5'b00100;
    localparam logic [4:0] DOWN  = 5'b01000;
    localparam logic [4:0] SEL   = 5'b10000;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_left, btn_right, btn_up, btn_down, btn_select;
    logic [2:0]  sel_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    logic        zero = 1'b0;
    logic        one  = 1'b1;
    logic        b2_right;
    logic [2:0]  sel2;
    logic        valid2;
    logic [31:0] out2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sprite_pos_stream u_dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_select (btn_select),
        .sel_idx    (sel_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out)
    );

    sprite_pos_stream #(
        .NUM_SPRITES (2),
        .X_MIN       (1),
        .STEP        (2)
    ) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (zero),
        .btn_right  (b2_right),
        .btn_up     (zero),
        .btn_down   (zero),
        .btn_select (zero),
        .sel_idx    (sel2),
        .out_valid  (valid2),
        .out_ready  (one),
        .out        (out2)
    );

    function automatic logic [31:0] mk_word(input int k, input int x, input int y);
        return {3'b001, 10'(x), 10'(y), 9'(k)};
    endfunction

    task automatic drive(input logic [4:0] b);
        {btn_select, btn_down, btn_up, btn_right, btn_left} = b;
    endtask

    task automatic hold(input logic [4:0] b, input int n);
        @(negedge clk);
        drive(b);
        repeat (n) @(negedge clk);
        drive(5'b0);
    endtask

    task automatic press(input logic [4:0] b);
        hold(b, 1);
    endtask

    // Next freshly loaded word for sprite k; X on timeout.
    task automatic get_word(input int k, output logic [31:0] w);
        w = 'x;
        @(posedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1 && out[8:0] === 9'(k)) begin
                w = out;
                return;
            end
        end
    endtask

    task automatic get_word2(output logic [31:0] w);
        w = 'x;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid2 === 1'b1 && out2[8:0] === 9'd0) begin
                w = out2;
                return;
            end
        end
    endtask

    task automatic test_reset;
        logic [31:0] exp;
        repeat (3) @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL reset_out: got %h want 0", out); end
        total++; if (sel_idx !== 3'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", sel_idx); end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            exp = mk_word(i % 4, 0, 0);
            total++;
            if (out_valid !== 1'b1 || out !== exp) begin
                bad++;
                $display("FAIL stream_%0d: got v=%b %h want v=1 %h", i, out_valid, out, exp);
            end
        end
    endtask

    task automatic test_single_step;
        logic [31:0] w;
        press(RIGHT);
        get_word(0, w);
        total++; if (w !== mk_word(0, 1, 0)) begin bad++; $display("FAIL single_step: got %h want %h", w, mk_word(0, 1, 0)); end
    endtask

    task automatic test_hold;
        logic [31:0] w;
        int n[4]   = '{20, 8, 9, 13};
        int xe[4]  = '{5, 6, 8, 11};
        for (int i = 0; i < 4; i++) begin
            hold(RIGHT, n[i]);
            get_word(0, w);
            total++;
            if (w !== mk_word(0, xe[i], 0)) begin
                bad++;
                $display("FAIL hold_%0d: got %h want %h", n[i], w, mk_word(0, xe[i], 0));
            end
        end
    endtask

    task automatic test_opposing;
        logic [31:0] w;
        @(negedge clk);
        drive(LEFT | RIGHT | DOWN);
        @(negedge clk);
        drive(LEFT | RIGHT);
        repeat (9) @(negedge clk);
        drive(5'b0);
        get_word(0, w);
        total++; if (w !== mk_word(0, 11, 1)) begin bad++; $display("FAIL opposing: got %h want %h", w, mk_word(0, 11, 1)); end
        press(RIGHT | DOWN);
        get_word(0, w);
        total++; if (w !== mk_word(0, 12, 2)) begin bad++; $display("FAIL diag: got %h want %h", w, mk_word(0, 12, 2)); end
    endtask

    task automatic test_select;
        logic [31:0] w;
        press(SEL);
        total++; if (sel_idx !== 3'd1) begin bad++; $display("FAIL sel_1: got %0d want 1", sel_idx); end
        repeat (3) press(DOWN);
        get_word(1, w);
        total++; if (w !== mk_word(1, 0, 3)) begin bad++; $display("FAIL sel_move: got %h want %h", w, mk_word(1, 0, 3)); end
        get_word(0, w);
        total++; if (w !== mk_word(0, 12, 2)) begin bad++; $display("FAIL sel_other: got %h want %h", w, mk_word(0, 12, 2)); end
        press(SEL | RIGHT);
        total++; if (sel_idx !== 3'd2) begin bad++; $display("FAIL sel_2: got %0d want 2", sel_idx); end
        get_word(1, w);
        total++; if (w !== mk_word(1, 0, 3)) begin bad++; $display("FAIL sel_nomove1: got %h want %h", w, mk_word(1, 0, 3)); end
        get_word(2, w);
        total++; if (w !== mk_word(2, 0, 0)) begin bad++; $display("FAIL sel_nomove2: got %h want %h", w, mk_word(2, 0, 0)); end
        press(SEL);
        press(SEL);
        total++; if (sel_idx !== 3'd0) begin bad++; $display("FAIL sel_wrap: got %0d want 0", sel_idx); end
    endtask

    task automatic test_stall;
        logic [31:0] w;
        logic [31:0] held;
        @(negedge clk);
        out_ready = 1'b0;
        held = out;
        for (int i = 0; i < 10; i++) begin
            btn_right = (i % 2 == 0) && (i < 6);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || out !== held) begin
                bad++;
                $display("FAIL stall_%0d: got v=%b %h want v=1 %h", i, out_valid, out, held);
            end
        end
        btn_right = 1'b0;
        out_ready = 1'b1;
        get_word(0, w);
        total++; if (w !== mk_word(0, 15, 2)) begin bad++; $display("FAIL stall_after: got %h want %h", w, mk_word(0, 15, 2)); end
    endtask

    task automatic test_low_bound;
        logic [31:0] w;
        int ye;
`ifdef SPRITE_POS_WRAP_EN
        ye = 460;
`else
        ye = 0;
`endif
        repeat (3) press(UP);
        get_word(0, w);
        total++; if (w !== mk_word(0, 15, ye)) begin bad++; $display("FAIL low_bound: got %h want %h", w, mk_word(0, 15, ye)); end
    endtask

    task automatic test_step2_bound;
        logic [31:0] w;
        int xe;
`ifdef SPRITE_POS_WRAP_EN
        xe = 1;
`else
        xe = 620;
`endif
        for (int i = 0; i < 309; i++) begin
            @(negedge clk);
            b2_right = 1'b1;
            @(negedge clk);
            b2_right = 1'b0;
        end
        get_word2(w);
        total++; if (w !== mk_word(0, 619, 0)) begin bad++; $display("FAIL step2_619: got %h want %h", w, mk_word(0, 619, 0)); end
        @(negedge clk);
        b2_right = 1'b1;
        @(negedge clk);
        b2_right = 1'b0;
        get_word2(w);
        total++; if (w !== mk_word(0, xe, 0)) begin bad++; $display("FAIL step2_top: got %h want %h", w, mk_word(0, xe, 0)); end
    endtask

    task automatic test_reset_stall;
        logic [31:0] w;
        press(SEL);
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        reset = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_stall_valid: got %b want 0", out_valid); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_stall_out: got %h want 0", out); end
        total++; if (sel_idx !== 3'd0) begin bad++; $display("FAIL rst_stall_sel: got %0d want 0", sel_idx); end
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out !== mk_word(0, 0, 0)) begin
            bad++;
            $display("FAIL rst_first: got v=%b %h want v=1 %h", out_valid, out, mk_word(0, 0, 0));
        end
        get_word(1, w);
        total++; if (w !== mk_word(1, 0, 0)) begin bad++; $display("FAIL rst_sprite1: got %h want %h", w, mk_word(1, 0, 0)); end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        b2_right  = 1'b0;
        drive(5'b0);
        test_reset();
        test_single_step();
        test_hold();
        test_opposing();
        test_select();
        test_stall();
        test_low_bound();
        test_step2_bound();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
